config_loader: RTL and testbench
================================

// Module: config_loader
// PURPOSE
//  Upstream configuration stage for the logic-block array.
//  Accepts a valid/ready stream of 32-bit words as (address, data) pairs.
//  Each pair becomes one config-write pulse to the addressed tile: one-hot
//  cfg_en bit plus a shared cfg_data bus. Counts completed writes and flags
//  out-of-range addresses.
// PARAMETERS
//  NUM_TILES  16  number of logic blocks driven; cfg_en width; must be >= 1
//  DATA_W     32  width of in_data and cfg_data
//  CNT_W      16  width of the write counter
// PORTS
//  clk        in   1          clock; all state updates on posedge
//  rst        in   1          async reset, active-high
//  in_valid   in   1          producer has a word on in_data
//  in_data    in   DATA_W     stream word: address, then data, alternating
//  in_ready   out  1          loader accepts in_data this cycle
//  clear_err  in   1          sync clear of err_addr
//  cfg_en     out  NUM_TILES  one-hot write strobe, one bit per tile
//  cfg_data   out  DATA_W     config word to all tiles
//  write_cnt  out  CNT_W      completed in-range writes, saturating
//  err_addr   out  1          sticky: an out-of-range address was received
//  busy       out  1          mid-pair or writing (state != S_ADDR)
// BEHAVIOUR
//  - Handshake: a word transfers on a posedge with in_valid && in_ready.
//    in_ready depends only on state, never on in_valid.
//    in_data need not be held once transferred.
//  - FSM states: S_ADDR, S_DATA, S_WRITE.
//    S_ADDR : in_ready=1; on transfer, addr_reg<=in_data; go to S_DATA.
//    S_DATA : in_ready=1; on transfer, cfg_data<=in_data; go to S_WRITE.
//             While waiting for in_valid, stay in S_DATA; addr_reg is held.
//    S_WRITE: in_ready=0; lasts exactly 1 cycle, then go to S_ADDR.
//  - cfg_en is a register. It is nonzero only during S_WRITE, where
//    cfg_en[addr_reg]=1 and all other bits are 0.
//  - cfg_data is registered. It changes only on a data-word transfer and
//    holds its value between writes.
//  - Timing: data word transfers at edge k. cfg_en is high for the cycle
//    k..k+1. The target tile captures cfg_data at edge k+1.
//  - Throughput is at most one write per 3 cycles.
//  - Range check compares the full DATA_W-bit addr_reg against NUM_TILES.
//    If addr_reg >= NUM_TILES, S_WRITE still lasts 1 cycle but cfg_en stays
//    all-zero and write_cnt is unchanged. err_addr is set at the end of that
//    S_WRITE cycle.
//  - write_cnt increments by 1 at the end of each in-range S_WRITE cycle.
//    It saturates at all-ones and does not wrap.
//  - err_addr is sticky and cleared by clear_err. If a set and clear_err
//    coincide on the same edge, set wins (err_addr=1).
//  - Reset values: state=S_ADDR, in_ready=1, cfg_en=0, cfg_data=0,
//    write_cnt=0, err_addr=0, busy=0, addr_reg=0.
//  - Reset mid-operation: any partial pair or pending write is discarded,
//    and no cfg_en pulse is emitted. The first word after reset is an address.
//  - No X on outputs after reset. No combinational path from in_data to any
//    output.
// TESTING
//  1. Reset: assert rst with in_valid=1 -> in_ready=1, cfg_en=0, cfg_data=0,
//     write_cnt=0, err_addr=0, busy=0.
//  2. Single write: send 3 then 0x2 back-to-back -> in the cycle after the
//     data edge, cfg_en=16'h0008 and cfg_data=2. cfg_en=0 in the next cycle.
//     write_cnt=1.
//  3. Stalls: send 5, drop in_valid for 4 cycles, then send 0x1 -> busy=1
//     and no cfg_en during the stall; then cfg_en=16'h0020 for 1 cycle.
//  4. Bad address: send 16 then 0x2, then 0xFFFF_FFFF then 0x0 ->
//     cfg_en stays 0, err_addr=1, write_cnt unchanged.
//     clear_err on a later idle cycle -> err_addr=0.
//     clear_err on the S_WRITE-end edge of a bad pair -> err_addr stays 1.
//  5. Reset mid-pair: send address 7, assert rst for 1 cycle, then send 2
//     then 0x1 -> only cfg_en[2] pulses; cfg_en[7] never pulses.
//  6. Saturation, CNT_W=4: perform 17 valid writes -> write_cnt stops at 15.
//     Streaming with in_valid held high gives exactly 1 cfg_en pulse per
//     3 cycles.

Source files
------------

// File: rtl/config_loader.sv
// config_loader: turns an (address, data) word stream into one-hot tile config writes.
// Latency: cfg_en/cfg_data are valid the cycle after the data word transfers.
// Backpressure: in_ready drops for the single write cycle only; at most one write per 3 cycles.
//
// Ports:
//   clk, rst           clock and async active-high reset
//   in_valid/in_ready  word stream handshake (in_ready is a function of state only)
//   in_data            stream word: address first, then data, alternating
//   clear_err          synchronous clear of the sticky err_addr flag
//   cfg_en             registered one-hot write strobe, one bit per tile
//   cfg_data           registered config word shared by all tiles
//   write_cnt          saturating count of completed in-range writes
//   err_addr           sticky out-of-range address flag
//   busy               high whenever a pair is in progress or being written
module config_loader #(
  parameter int NUM_TILES = 16,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  input  logic                 clear_err,
  output logic [NUM_TILES-1:0] cfg_en,
  output logic [DATA_W-1:0]    cfg_data,
  output logic [CNT_W-1:0]     write_cnt,
  output logic                 err_addr,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_ADDR  = 2'd0,
    S_DATA  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Range check is done on the full address width so that huge addresses
  // cannot alias onto a valid tile through truncation.
  localparam logic [DATA_W-1:0] LP_NUM_TILES = DATA_W'(NUM_TILES);
  localparam logic [CNT_W-1:0]  LP_CNT_MAX   = '1;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [DATA_W-1:0]      r_addr;
  logic [NUM_TILES-1:0]   r_cfg_en;
  logic [DATA_W-1:0]      r_cfg_data;
  logic [CNT_W-1:0]       r_write_cnt;
  logic                   r_err_addr;

  logic                   w_in_ready;
  logic                   w_busy;
  logic                   w_xfer;
  logic                   w_addr_xfer;
  logic                   w_data_xfer;
  logic                   w_in_range;
  logic [NUM_TILES-1:0]   w_onehot;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ADDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_ADDR:  if (in_valid) w_next_state = S_DATA;
      S_DATA:  if (in_valid) w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_ADDR;
      default: w_next_state = S_ADDR;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (state-decoded only, so in_ready never sees in_valid)
  // ---------------------------------------------------------------------
  always_comb begin
    w_in_ready = 1'b1;
    w_busy     = 1'b0;
    case (r_state)
      S_ADDR: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
      end
      S_DATA: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
      S_WRITE: begin
        w_in_ready = 1'b0;
        w_busy     = 1'b1;
      end
      default: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
      end
    endcase
  end

  assign w_xfer      = in_valid && w_in_ready;
  assign w_addr_xfer = w_xfer && (r_state == S_ADDR);
  assign w_data_xfer = w_xfer && (r_state == S_DATA);

  // ---------------------------------------------------------------------
  // Address decode. r_addr is stable from the address transfer through
  // the end of S_WRITE, so both the strobe and the end-of-write bookkeeping
  // can use it directly.
  // ---------------------------------------------------------------------
  assign w_in_range = (r_addr < LP_NUM_TILES);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      w_onehot[i] = (r_addr == DATA_W'(i));
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
    end else if (w_addr_xfer) begin
      r_addr <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_data <= '0;
    end else if (w_data_xfer) begin
      r_cfg_data <= in_data;
    end
  end

  // Strobe is loaded on the data edge so it is high exactly for the
  // S_WRITE cycle; every other edge clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cfg_en <= '0;
    end else if (w_data_xfer && w_in_range) begin
      r_cfg_en <= w_onehot;
    end else begin
      r_cfg_en <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write_cnt <= '0;
    end else if ((r_state == S_WRITE) && w_in_range && (r_write_cnt != LP_CNT_MAX)) begin
      r_write_cnt <= r_write_cnt + 1'b1;
    end
  end

  // Set has priority over clear when both land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_addr <= 1'b0;
    end else if ((r_state == S_WRITE) && !w_in_range) begin
      r_err_addr <= 1'b1;
    end else if (clear_err) begin
      r_err_addr <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign cfg_en    = r_cfg_en;
  assign cfg_data  = r_cfg_data;
  assign write_cnt = r_write_cnt;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed bench for config_loader (NUM_TILES=16, DATA_W=32, CNT_W=4).
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: bench waits on in_ready with a bounded cycle budget.
module tb_config_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        clear_err;
  logic [15:0] cfg_en;
  logic [31:0] cfg_data;
  logic [3:0]  write_cnt;
  logic        err_addr;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic mon7;
  logic seen7;

  config_loader #(
    .NUM_TILES (16),
    .DATA_W    (32),
    .CNT_W     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clear_err (clear_err),
    .cfg_en    (cfg_en),
    .cfg_data  (cfg_data),
    .write_cnt (write_cnt),
    .err_addr  (err_addr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records any pulse on tile 7 while armed; disarming clears it.
  always @(negedge clk) begin
    seen7 <= mon7 ? (seen7 | cfg_en[7]) : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and returns 1ns after the edge on which it transferred.
  task automatic send_word(input logic [31:0] w);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && guard < 8) begin
      step();
      guard++;
    end
    chk("rdy_before_send", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int w;
    int pulses;
    int last;
    int exp_cnt;

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h3;
    clear_err = 1'b0;
    mon7      = 1'b0;
    #1;

    // 1. Reset with in_valid high
    step(); step(); step();
    chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    chk("rst_cfg_en",    {16'b0, cfg_en},   32'd0);
    chk("rst_cfg_data",  cfg_data,          32'd0);
    chk("rst_write_cnt", {28'b0, write_cnt}, 32'd0);
    chk("rst_err_addr",  {31'b0, err_addr}, 32'd0);
    chk("rst_busy",      {31'b0, busy},     32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();

    // 2. Single write to tile 3
    send_word(32'd3);
    chk("w1_busy_mid", {31'b0, busy}, 32'd1);
    send_word(32'h2);
    chk("w1_cfg_en",   {16'b0, cfg_en},   32'h0008);
    chk("w1_cfg_data", cfg_data,          32'h2);
    chk("w1_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    chk("w1_en_off",   {16'b0, cfg_en},    32'd0);
    chk("w1_cnt",      {28'b0, write_cnt}, 32'd1);
    chk("w1_idle",     {31'b0, busy},      32'd0);

    // 3. Stall between address and data
    send_word(32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("stall_busy", {31'b0, busy},   32'd1);
      chk("stall_en",   {16'b0, cfg_en}, 32'd0);
      step();
    end
    send_word(32'h1);
    chk("w2_cfg_en",   {16'b0, cfg_en}, 32'h0020);
    chk("w2_cfg_data", cfg_data,        32'h1);
    step();
    chk("w2_en_off",   {16'b0, cfg_en},    32'd0);
    chk("w2_cnt",      {28'b0, write_cnt}, 32'd2);
    chk("w2_data_hold", cfg_data,          32'h1);

    // 4. Out-of-range addresses
    send_word(32'd16);
    send_word(32'h2);
    chk("bad16_en",      {16'b0, cfg_en},   32'd0);
    chk("bad16_err_pre", {31'b0, err_addr}, 32'd0);
    step();
    chk("bad16_err",     {31'b0, err_addr},  32'd1);
    chk("bad16_cnt",     {28'b0, write_cnt}, 32'd2);
    send_word(32'hFFFF_FFFF);
    send_word(32'h0);
    chk("badff_en",      {16'b0, cfg_en},    32'd0);
    step();
    chk("badff_err",     {31'b0, err_addr},  32'd1);
    chk("badff_cnt",     {28'b0, write_cnt}, 32'd2);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("clr_err",       {31'b0, err_addr},  32'd0);
    send_word(32'd16);
    send_word(32'h0);
    clear_err = 1'b1;      // coincides with the end of the bad S_WRITE
    step();
    clear_err = 1'b0;
    chk("set_beats_clr", {31'b0, err_addr},  32'd1);

    // 5. Reset mid-pair
    mon7 = 1'b1;
    step();
    send_word(32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy},      32'd0);
    chk("midrst_en",   {16'b0, cfg_en},    32'd0);
    chk("midrst_err",  {31'b0, err_addr},  32'd0);
    chk("midrst_cnt",  {28'b0, write_cnt}, 32'd0);
    step(); step();
    send_word(32'd2);
    send_word(32'h1);
    chk("midrst_en2",  {16'b0, cfg_en}, 32'h0004);
    step(); step();
    chk("midrst_no7",  {31'b0, seen7},  32'd0);
    mon7 = 1'b0;

    // 6. Saturation and streaming throughput
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("sat_rst_cnt", {28'b0, write_cnt}, 32'd0);
    w = 0;
    pulses = 0;
    last = 0;
    for (int cyc = 0; cyc < 200 && pulses < 17; cyc++) begin
      if (cfg_en != 16'd0) begin
        pulses++;
        exp_cnt = (pulses - 1 > 15) ? 15 : pulses - 1;
        chk("stream_en",   {16'b0, cfg_en},    32'd1 << ((pulses - 1) % 16));
        chk("stream_data", cfg_data,           32'h100 + 32'(pulses - 1));
        chk("stream_cnt",  {28'b0, write_cnt}, 32'(exp_cnt));
        if (pulses > 1) chk("stream_gap", 32'(cyc - last), 32'd3);
        last = cyc;
      end
      if (w < 34) begin
        in_valid = 1'b1;
        if (in_ready) begin
          in_data = (w % 2 == 0) ? 32'((w / 2) % 16) : 32'h100 + 32'(w / 2);
          w++;
        end
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    chk("stream_pulses", 32'(pulses), 32'd17);
    step();
    chk("sat_cnt",  {28'b0, write_cnt}, 32'd15);
    chk("sat_busy", {31'b0, busy},      32'd0);
    chk("sat_err",  {31'b0, err_addr},  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
